// File: rtl/prefetch_queue_if.sv
// Prefetch queue signal bundle: memory-bus side plus decoder-facing queue view.
// The core drives through master; the queue itself connects as slave.
interface prefetch_queue_if #(
    parameter int unsigned DEPTH = 6
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          flush;
    logic [15:0]   new_cs;
    logic [15:0]   new_ip;
    logic          bus_busy;
    logic [7:0]    mem_data;
    logic [19:0]   mem_address;
    logic          mem_req;
    logic [1:0]    consume;
    logic [CW-1:0] q_count;
    logic [7:0]    q_byte0;
    logic [7:0]    q_byte1;
    logic [15:0]   q_ip;
    logic [15:0]   q_cs;
    logic          err;

    modport master (
        output flush, new_cs, new_ip, bus_busy, mem_data, consume,
        input  mem_address, mem_req, q_count, q_byte0, q_byte1, q_ip, q_cs, err
    );

    modport slave (
        input  flush, new_cs, new_ip, bus_busy, mem_data, consume,
        output mem_address, mem_req, q_count, q_byte0, q_byte1, q_ip, q_cs, err
    );
endinterface

// File: rtl/prefetch_queue.sv
// Byte-wide x86 instruction prefetch queue: fills from CS:IP whenever the bus
// is idle and exposes the two oldest bytes for 0/1/2-byte decode per cycle.
module prefetch_queue #(
    parameter int unsigned DEPTH    = 6,
    parameter logic [15:0] RESET_CS = 16'hFFFF,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input logic             clock,
    input logic             reset_n,
    prefetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = PW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fetch_cs_q, fetch_cs_d;
    logic [15:0]   fetch_ip_q, fetch_ip_d;
    logic [15:0]   q_ip_q, q_ip_d;
    logic [15:0]   q_cs_q, q_cs_d;
    logic          err_q, err_d;
    logic          fetch_c;
    logic          consume_ok_c;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] inc);
        logic [SW-1:0] sum;
        sum = {1'b0, ptr} + SW'(inc);
        if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
        return sum[PW-1:0];
    endfunction

    // Fetch decision looks only at registered occupancy, never count-minus-consume.
    assign fetch_c      = reset_n && !bus.flush && !bus.bus_busy && (count_q < CW'(DEPTH));
    assign consume_ok_c = (bus.consume != 2'd3) && (CW'(bus.consume) <= count_q);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_cs_d = fetch_cs_q;
        fetch_ip_d = fetch_ip_q;
        q_ip_d     = q_ip_q;
        q_cs_d     = q_cs_q;
        err_d      = err_q;
        if (bus.flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_cs_d = bus.new_cs;
            q_cs_d     = bus.new_cs;
            fetch_ip_d = bus.new_ip;
            q_ip_d     = bus.new_ip;
        end else begin
            if (fetch_c) begin
                wr_ptr_d   = ptr_add(wr_ptr_q, 2'd1);
                fetch_ip_d = fetch_ip_q + 16'd1;
            end
            if (consume_ok_c) begin
                rd_ptr_d = ptr_add(rd_ptr_q, bus.consume);
                q_ip_d   = q_ip_q + 16'(bus.consume);
            end else begin
                err_d = 1'b1;
            end
            count_d = count_q + CW'(fetch_c) - (consume_ok_c ? CW'(bus.consume) : CW'(0));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            q_ip_q     <= RESET_IP;
            q_cs_q     <= RESET_CS;
            err_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            q_ip_q     <= q_ip_d;
            q_cs_q     <= q_cs_d;
            err_q      <= err_d;
        end
    end

    // Byte storage carries no reset; q_count qualifies validity.
    always_ff @(posedge clock) begin
        if (fetch_c) mem_q[wr_ptr_q] <= bus.mem_data;
    end

    assign bus.mem_req     = fetch_c;
    assign bus.mem_address = {fetch_cs_q, 4'h0} + {4'h0, fetch_ip_q};
    assign bus.q_count     = count_q;
    assign bus.q_byte0     = mem_q[rd_ptr_q];
    assign bus.q_byte1     = mem_q[ptr_add(rd_ptr_q, 2'd1)];
    assign bus.q_ip        = q_ip_q;
    assign bus.q_cs        = q_cs_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: scoreboard of fetched bytes plus
// directed checks of reset, fill, drain, flush, bus_busy, wrap and err.
module tb_prefetch_queue;
    localparam int unsigned DEPTH = 6;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_fcs, m_fip, m_qip, m_qcs;
    logic        m_err;
    logic [7:0]  sb[$];
    logic        exp_req;
    logic [19:0] exp_addr;

    always #5 clock = ~clock;

    prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    // Memory returns the low address byte.
    assign bus.mem_data = bus.mem_address[7:0];

    prefetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_CS(16'hFFFF),
        .RESET_IP(16'h0000)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fcs = 16'hFFFF;
        m_qcs = 16'hFFFF;
        m_fip = 16'h0000;
        m_qip = 16'h0000;
        m_err = 1'b0;
        sb.delete();
    endtask

    task automatic drive(input logic fl, input logic [15:0] cs, input logic [15:0] ip,
                         input logic busy, input logic [1:0] cons);
        @(negedge clock);
        bus.flush    = fl;
        bus.new_cs   = cs;
        bus.new_ip   = ip;
        bus.bus_busy = busy;
        bus.consume  = cons;
        #1;
        exp_req  = reset_n && !fl && !busy && (sb.size() < DEPTH);
        exp_addr = {m_fcs, 4'h0} + {4'h0, m_fip};
        check("mem_req", 32'(bus.mem_req), 32'(exp_req));
        check("mem_address", 32'(bus.mem_address), 32'(exp_addr));
    endtask

    task automatic tick();
        bit legal;
        @(posedge clock);
        if (bus.flush) begin
            sb.delete();
            m_fcs = bus.new_cs;
            m_qcs = bus.new_cs;
            m_fip = bus.new_ip;
            m_qip = bus.new_ip;
        end else begin
            legal = (bus.consume != 2'd3) && (int'(bus.consume) <= sb.size());
            if (legal) begin
                repeat (int'(bus.consume)) void'(sb.pop_front());
                m_qip = m_qip + 16'(bus.consume);
            end else begin
                m_err = 1'b1;
            end
            if (exp_req) begin
                sb.push_back(exp_addr[7:0]);
                m_fip = m_fip + 16'd1;
            end
        end
        #1;
        check("q_count", 32'(bus.q_count), 32'(sb.size()));
        check("q_ip", 32'(bus.q_ip), 32'(m_qip));
        check("q_cs", 32'(bus.q_cs), 32'(m_qcs));
        check("err", 32'(bus.err), 32'(m_err));
        if (sb.size() >= 1) check("q_byte0", 32'(bus.q_byte0), 32'(sb[0]));
        if (sb.size() >= 2) check("q_byte1", 32'(bus.q_byte1), 32'(sb[1]));
    endtask

    task automatic step(input logic fl, input logic [15:0] cs, input logic [15:0] ip,
                        input logic busy, input logic [1:0] cons);
        drive(fl, cs, ip, busy, cons);
        tick();
    endtask

    initial begin
        logic [7:0]  drain_b0 [3];
        logic [7:0]  drain_b1 [3];
        logic [19:0] wrap_addr [3];
        logic [15:0] wrap_ip [2];
        logic [1:0]  cons;
        logic        busy;

        drain_b0  = '{8'hF2, 8'hF4, 8'hF6};
        drain_b1  = '{8'hF3, 8'hF5, 8'hF7};
        wrap_addr = '{20'hFFFFE, 20'hFFFFF, 20'hF0000};
        wrap_ip   = '{16'hFFFF, 16'h0000};

        bus.flush    = 1'b0;
        bus.new_cs   = '0;
        bus.new_ip   = '0;
        bus.bus_busy = 1'b0;
        bus.consume  = '0;
        reset_n      = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_q_count", 32'(bus.q_count), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'hFFFF0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_q_ip", 32'(bus.q_ip), 32'h0000);
        check("rst_q_cs", 32'(bus.q_cs), 32'hFFFF);

        // Fill after reset release
        @(posedge clock);
        #2 reset_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        check("first_fetch_addr", 32'(bus.mem_address), 32'hFFFF0);
        check("first_fetch_req", 32'(bus.mem_req), 32'd1);
        tick();
        repeat (5) step(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        check("full_no_req", 32'(bus.mem_req), 32'd0);
        tick();
        check("full_count", 32'(bus.q_count), 32'd6);
        check("full_q_ip", 32'(bus.q_ip), 32'h0000);
        check("full_byte0", 32'(bus.q_byte0), 32'hF0);

        // Drain two per cycle across the buffer wrap
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 2'd2);
            check("drain_byte0", 32'(bus.q_byte0), 32'(drain_b0[i]));
            check("drain_byte1", 32'(bus.q_byte1), 32'(drain_b1[i]));
            check("drain_q_ip", 32'(bus.q_ip), 32'(16'(2 * (i + 1))));
        end

        // Random legal traffic with occasional flushes
        for (int i = 0; i < 80; i++) begin
            busy = ($urandom_range(0, 3) == 0);
            cons = 2'($urandom_range(0, 2));
            if (int'(cons) > sb.size()) cons = 2'(sb.size());
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 16'($urandom), 16'($urandom), busy, cons);
            else
                step(1'b0, 16'h0, 16'h0, busy, cons);
        end

        // Flush while four bytes queued and consume=1
        step(1'b1, 16'h0100, 16'h0000, 1'b0, 2'd0);
        repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        check("pre_flush_count", 32'(bus.q_count), 32'd4);
        step(1'b1, 16'h1234, 16'h0010, 1'b0, 2'd1);
        check("flush_count", 32'(bus.q_count), 32'd0);
        check("flush_q_ip", 32'(bus.q_ip), 32'h0010);
        check("flush_err", 32'(bus.err), 32'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        check("post_flush_addr", 32'(bus.mem_address), 32'h12350);
        tick();

        // bus_busy stall mid-fill
        step(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 2'd0);
            check("busy_no_req", 32'(bus.mem_req), 32'd0);
            tick();
            check("busy_count", 32'(bus.q_count), 32'd2);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        check("busy_resume_addr", 32'(bus.mem_address), 32'h12352);
        tick();

        // 20-bit address carry and IP wrap
        step(1'b1, 16'hF000, 16'hFFFE, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
            check("wrap_addr", 32'(bus.mem_address), 32'(wrap_addr[i]));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, 2'd1);
            check("wrap_q_ip", 32'(bus.q_ip), 32'(wrap_ip[i]));
        end

        // Illegal consume is ignored, err sticks across flush
        step(1'b1, 16'h2000, 16'h0000, 1'b0, 2'd0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 2'd2);
        check("illegal_err", 32'(bus.err), 32'd1);
        check("illegal_count", 32'(bus.q_count), 32'd1);
        check("illegal_q_ip", 32'(bus.q_ip), 32'h0000);
        step(1'b1, 16'h3000, 16'h0000, 1'b0, 2'd0);
        check("err_sticky", 32'(bus.err), 32'd1);

        // Asynchronous reset in the middle of a fill
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 2'd0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_count", 32'(bus.q_count), 32'd0);
        check("async_rst_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_addr", 32'(bus.mem_address), 32'hFFFF0);
        check("async_rst_err", 32'(bus.err), 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Byte-wide instruction prefetch queue for the x86 core: a successor to the core's single-byte fetch. It fetches code bytes from CS:IP over the shared 8-bit memory bus into a DEPTH-entry FIFO whenever the execution side leaves the bus idle. It presents the two oldest bytes so the decoder can consume 0, 1 or 2 bytes per cycle. A flush reloads CS:IP on jumps and far transfers.

## Interface
- DEPTH, 6: queue capacity in bytes; legal range 2..16.
- RESET_CS, 16'hFFFF: CS value after reset.
- RESET_IP, 16'h0000: IP value after reset.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard the queue and load new_cs:new_ip.
- new_cs  in  16  CS to load on flush.
- new_ip  in  16  IP to load on flush.
- bus_busy  in  1  execution side owns the bus this cycle; no fetch.
- mem_data  in  8  read data for mem_address, sampled on the same rising edge.
- mem_address  out  20  combinational: (fetch_cs<<4) + fetch_ip, modulo 2^20.
- mem_req  out  1  combinational: a fetch is performed this cycle.
- consume  in  2  number of bytes taken this cycle (0, 1, 2; 3 is illegal).
- q_count  out  clog2(DEPTH+1)  number of valid bytes.
- q_byte0  out  8  oldest byte, valid when q_count>=1.
- q_byte1  out  8  second-oldest byte, valid when q_count>=2.
- q_ip  out  16  IP of q_byte0.
- q_cs  out  16  CS in effect.
- err  out  1  sticky; set on an illegal consume, cleared only by reset.

## Operation
- State:
  - circular buffer of DEPTH bytes, with rd_ptr and wr_ptr counting modulo DEPTH;
  - q_count;
  - fetch_cs and fetch_ip (next byte to fetch);
  - q_ip;
  - err.
- mem_req = !reset-active && !flush && !bus_busy && (q_count < DEPTH). The decision uses the registered q_count, not count minus consume.
- While mem_req=1, mem_address and mem_req are driven from registered state. On the edge:
  - mem_data is written at wr_ptr;
  - wr_ptr advances;
  - fetch_ip advances by 1, wrapping FFFF→0000 with fetch_cs unchanged.
- Consume:
  - Legal when consume <= q_count and consume != 3.
  - A legal consume advances rd_ptr by consume and q_ip by consume (16-bit wrap).
  - An illegal consume is ignored entirely (no pointer or count change) and sets err.
- q_count_next = q_count + mem_req − legal_consume. Fetch and consume in the same cycle are both applied.
- Flush has priority over everything that cycle:
  - q_count, rd_ptr and wr_ptr go to 0;
  - fetch_cs and q_cs take new_cs;
  - fetch_ip and q_ip take new_ip;
  - consume is ignored and err is not set;
  - mem_req is 0.
- Address arithmetic: 20-bit sum; a carry beyond bit 19 is dropped (FFFF:0010 → 00000).
- q_byte0 and q_byte1 are read combinationally at rd_ptr and rd_ptr+1 modulo DEPTH. Their value is don't-care when not valid.

## Timing
- Reset values:
  - q_count=0, rd_ptr=wr_ptr=0, err=0;
  - fetch_cs=q_cs=RESET_CS, fetch_ip=q_ip=RESET_IP;
  - mem_address=(RESET_CS<<4)+RESET_IP, which is FFFF0 by default;
  - mem_req=0 while reset_n=0.
- Reset is asynchronous and may assert mid-fill; all state returns to reset values immediately.
- First fetch happens in the first cycle with reset_n=1.
- Latency: a byte fetched in cycle N is visible in q_count and q_byte0 from cycle N+1.
- After flush in cycle N:
  - the first fetch is in cycle N+1 at new_cs:new_ip;
  - q_count=1 from cycle N+2 (if bus_busy stays 0).
- Full (q_count=DEPTH) with consume=2: no fetch that cycle; q_count=DEPTH−2 next cycle; fetches resume the following cycle.
- Empty: consume must be 0; consume=1 sets err next cycle.
- Throughput: 1 byte per cycle into the queue, up to 2 bytes per cycle out.

## Test plan
- Reset released with bus_busy=0, consume=0: cycle 1 mem_address=FFFF0 and mem_req=1. The queue fills FFFF0..FFFF5 over 6 cycles, then q_count=6, mem_req=0, q_ip=0000, q_byte0=mem[FFFF0].
- Full queue plus consume=2 each cycle from memory pattern byte=addr[7:0]:
  - q_byte0/q_byte1 walk F0,F1 / F2,F3 / …;
  - q_ip advances by 2 per cycle;
  - no byte is lost or duplicated across the buffer wrap.
- Flush with new_cs=1234, new_ip=0010 while q_count=4 and consume=1:
  - next cycle q_count=0, q_ip=0010, consume ignored;
  - the following cycle mem_address=12350.
- bus_busy held high 3 cycles during a fill: mem_req=0 and q_count frozen, then fetching resumes at the same address.
- CS=F000, IP=FFFE, fetch 3 bytes: addresses FFFFE, FFFFF, F0000; q_ip wraps FFFE→FFFF→0000 on consume.
- q_count=1 with consume=2: no state change, err=1 and stays 1 across a later flush until reset_n=0.
